hkspi_responder: RTL and testbench

HKSPI_RESPONDER -- requirements
Module: hkspi_responder

---
 rtl/hkspi_pkg.sv | 34 +++
 rtl/hkspi_sync_edge.sv | 35 +++
 rtl/hkspi_responder.sv | 277 +++++++++++++++++++++++++++
 tb/tb_hkspi_responder.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/hkspi_pkg.sv
// hkspi_pkg: shared types for the housekeeping SPI responder.
// FSM states, command-mode encodings and command-field positions.
package hkspi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COMMAND,
    ST_ADDRESS,
    ST_DATA,
    ST_IGNORE
  } hkspi_state_t;

  localparam logic [1:0] MODE_WRITE = 2'b10;
  localparam logic [1:0] MODE_READ  = 2'b01;
  localparam logic [1:0] MODE_RDWR  = 2'b11;

  localparam int MODE_MSB = 7;
  localparam int MODE_LSB = 6;
  localparam int CNT_MSB  = 5;
  localparam int CNT_LSB  = 3;

  function automatic logic mode_reads(
    input logic [1:0] m
  );
    return (m == MODE_READ) || (m == MODE_RDWR);
  endfunction

  function automatic logic mode_writes(
    input logic [1:0] m
  );
    return (m == MODE_WRITE) || (m == MODE_RDWR);
  endfunction

endpackage

// File: rtl/hkspi_sync_edge.sv
// hkspi_sync_edge: multi-flop synchronizer for one async SPI pin,
// with rise/fall pulses derived from the synchronized level.
module hkspi_sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;
  logic [STAGES:0]   w_next;

  assign w_next  = {r_sync, i_async};
  assign o_level = r_sync[STAGES-1];
  assign o_rise  = o_level & ~r_prev;
  assign o_fall  = ~o_level & r_prev;

  // Shift the pin through the chain; remember last level for edges.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync <= {STAGES{RESET_VAL}};
      r_prev <= RESET_VAL;
    end else begin
      r_sync <= w_next[STAGES-1:0];
      r_prev <= o_level;
    end
  end

endmodule

// File: rtl/hkspi_responder.sv
// hkspi_responder: SPI target that turns command/address/data
// frames into single-cycle register read and write strobes.
module hkspi_responder
  import hkspi_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       SCK,
  input  logic       CSB,
  input  logic       SDI,
  output logic       SDO,
  output logic       sdo_oe,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata
);

  localparam logic [3:0] SETTLE = 4'(SYNC_STAGES);

  hkspi_state_t r_state;
  hkspi_state_t w_next_state;

  logic       w_sck_lvl;
  logic       w_sck_rise;
  logic       w_sck_fall;
  logic       w_csb_lvl;
  logic       w_csb_rise;
  logic       w_csb_fall;
  logic       w_sdi_lvl;
  logic       w_sdi_rise;
  logic       w_sdi_fall;
  logic       w_unused;

  logic [2:0] r_bitcnt;
  logic [6:0] r_shift;
  logic [1:0] r_mode;
  logic [2:0] r_count;
  logic [2:0] r_nbytes;
  logic [7:0] r_addr;
  logic [7:0] r_wdata;
  logic       r_we;
  logic       r_re;
  logic       r_load;
  logic       r_inc;
  logic       r_inc_re;
  logic [7:0] r_sdo_sr;
  logic       r_sdo;
  logic       r_oe;
  logic [3:0] r_settle;
  logic       r_armed;

  logic [7:0] w_byte;
  logic       w_active;
  logic       w_bit_last;
  logic       w_last_data;
  logic       w_rd;
  logic       w_wr;
  logic       w_settled;
  logic       w_sdo_run;

  hkspi_sync_edge #(
    .STAGES   (SYNC_STAGES),
    .RESET_VAL(1'b0)
  ) u_sync_sck (
    .clock  (clock),
    .reset  (reset),
    .i_async(SCK),
    .o_level(w_sck_lvl),
    .o_rise (w_sck_rise),
    .o_fall (w_sck_fall)
  );

  hkspi_sync_edge #(
    .STAGES   (SYNC_STAGES),
    .RESET_VAL(1'b1)
  ) u_sync_csb (
    .clock  (clock),
    .reset  (reset),
    .i_async(CSB),
    .o_level(w_csb_lvl),
    .o_rise (w_csb_rise),
    .o_fall (w_csb_fall)
  );

  hkspi_sync_edge #(
    .STAGES   (SYNC_STAGES),
    .RESET_VAL(1'b0)
  ) u_sync_sdi (
    .clock  (clock),
    .reset  (reset),
    .i_async(SDI),
    .o_level(w_sdi_lvl),
    .o_rise (w_sdi_rise),
    .o_fall (w_sdi_fall)
  );

  assign w_unused = &{1'b0, w_sck_lvl, w_csb_rise,
                      w_sdi_rise, w_sdi_fall};

  assign w_byte    = {r_shift, w_sdi_lvl};
  assign w_active  = !w_csb_lvl &&
                     (r_state == ST_COMMAND ||
                      r_state == ST_ADDRESS ||
                      r_state == ST_DATA);
  assign w_bit_last  = w_active && w_sck_rise &&
                       (r_bitcnt == 3'd7);
  assign w_last_data = (r_count != 3'd0) &&
                       (r_nbytes == r_count - 3'd1);
  assign w_rd      = mode_reads(r_mode);
  assign w_wr      = mode_writes(r_mode);
  assign w_settled = (r_settle == SETTLE);
  assign w_sdo_run = (r_state == ST_DATA) && w_rd &&
                     !w_csb_lvl;

  assign SDO       = r_sdo;
  assign sdo_oe    = r_oe;
  assign reg_addr  = r_addr;
  assign reg_wdata = r_wdata;
  assign reg_we    = r_we;
  assign reg_re    = r_re;

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state: CSB high always wins; bytes advance the frame.
  always_comb begin
    w_next_state = r_state;
    if (w_csb_lvl) begin
      w_next_state = ST_IDLE;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_csb_fall && r_armed) begin
            w_next_state = ST_COMMAND;
          end
        end
        ST_COMMAND: begin
          if (w_bit_last) begin
            if (w_byte[MODE_MSB:MODE_LSB] == 2'b00) begin
              w_next_state = ST_IGNORE;
            end else begin
              w_next_state = ST_ADDRESS;
            end
          end
        end
        ST_ADDRESS: begin
          if (w_bit_last) begin
            w_next_state = ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_bit_last && w_last_data) begin
            w_next_state = ST_IGNORE;
          end
        end
        ST_IGNORE: begin
          w_next_state = ST_IGNORE;
        end
        default: begin
          w_next_state = ST_IDLE;
        end
      endcase
    end
  end

  // Arm only once CSB is seen high after the chain has flushed,
  // so a reset in mid-frame cannot fake a CSB fall.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_settle <= '0;
      r_armed  <= 1'b0;
    end else if (!w_settled) begin
      r_settle <= r_settle + 4'd1;
    end else if (w_csb_lvl) begin
      r_armed <= 1'b1;
    end
  end

  // Bit counter and input shifter; cleared outside a live frame.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_bitcnt <= '0;
      r_shift  <= '0;
    end else if (!w_active) begin
      r_bitcnt <= '0;
      r_shift  <= '0;
    end else if (w_sck_rise) begin
      r_bitcnt <= r_bitcnt + 3'd1;
      r_shift  <= w_byte[6:0];
    end
  end

  // Byte handling: command capture, address, strobes, increment.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_mode   <= '0;
      r_count  <= '0;
      r_nbytes <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_we     <= 1'b0;
      r_re     <= 1'b0;
      r_load   <= 1'b0;
      r_inc    <= 1'b0;
      r_inc_re <= 1'b0;
    end else begin
      r_we   <= 1'b0;
      r_re   <= 1'b0;
      r_inc  <= 1'b0;
      r_load <= r_re;
      if (r_inc) begin
        r_addr <= r_addr + 8'd1;
        r_re   <= r_inc_re;
      end
      if (w_bit_last) begin
        unique case (r_state)
          ST_COMMAND: begin
            r_mode   <= w_byte[MODE_MSB:MODE_LSB];
            r_count  <= w_byte[CNT_MSB:CNT_LSB];
            r_nbytes <= '0;
          end
          ST_ADDRESS: begin
            r_addr <= w_byte;
            r_re   <= w_rd;
          end
          ST_DATA: begin
            r_nbytes <= r_nbytes + 3'd1;
            if (w_wr) begin
              r_we     <= 1'b1;
              r_wdata  <= w_byte;
              r_inc    <= 1'b1;
              r_inc_re <= w_rd && !w_last_data;
            end else begin
              r_addr <= r_addr + 8'd1;
              r_re   <= !w_last_data;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  // SDO shifter: load read data, present MSB on each SCK fall.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_sdo_sr <= '0;
      r_sdo    <= 1'b0;
      r_oe     <= 1'b0;
    end else begin
      if (r_load) begin
        r_sdo_sr <= reg_rdata;
      end else if (w_sdo_run && w_sck_fall) begin
        r_sdo_sr <= {r_sdo_sr[6:0], 1'b0};
      end
      if (!w_sdo_run) begin
        r_sdo <= 1'b0;
        r_oe  <= 1'b0;
      end else if (w_sck_fall) begin
        r_sdo <= r_sdo_sr[7];
        r_oe  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hkspi_responder.sv
// tb_hkspi_responder: random and directed SPI frames checked
// against a frame-level model of the register traffic.
module tb_hkspi_responder;

  localparam int HALF = 63;

  logic       clock = 1'b0;
  logic       reset;
  logic       SCK;
  logic       CSB;
  logic       SDI;
  logic       SDO;
  logic       sdo_oe;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] rd_q = 8'h00;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]  mem     [0:255];
  logic [7:0]  mdl_mem [0:255];
  logic [7:0]  tx      [0:31];
  logic [7:0]  rx      [0:31];
  int          oecnt   [0:31];
  bit          exp_oe  [0:31];
  logic [7:0]  exp_rd  [0:31];
  logic [15:0] cap_we[$];
  logic [7:0]  cap_re[$];
  logic [15:0] exp_we[$];
  logic [7:0]  exp_re[$];

  hkspi_responder #(
    .SYNC_STAGES(2)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .SCK      (SCK),
    .CSB      (CSB),
    .SDI      (SDI),
    .SDO      (SDO),
    .sdo_oe   (sdo_oe),
    .reg_addr (reg_addr),
    .reg_wdata(reg_wdata),
    .reg_we   (reg_we),
    .reg_re   (reg_re),
    .reg_rdata(rd_q)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Register file side: capture strobes, serve reads one cycle later.
  always @(negedge clock) begin
    if (reg_we || reg_re)
      chk("we_re_excl", {31'd0, reg_we & reg_re}, 32'd0);
    if (reg_we) begin
      cap_we.push_back({reg_addr, reg_wdata});
      mem[reg_addr] = reg_wdata;
    end
    if (reg_re) begin
      cap_re.push_back(reg_addr);
      rd_q = mem[reg_addr];
    end
  end

  // Frame model: what a correct responder does with nfull bytes.
  task automatic model_txn(input int nfull);
    logic [1:0] m;
    logic [2:0] n;
    logic [7:0] a;
    bit         live;
    exp_we.delete();
    exp_re.delete();
    for (int i = 0; i < 32; i++) begin
      exp_oe[i] = 1'b0;
      exp_rd[i] = 8'h00;
    end
    if (nfull < 2) return;
    m = tx[0][7:6];
    n = tx[0][5:3];
    if (m == 2'b00) return;
    a = tx[1];
    if (m[0]) exp_re.push_back(a);
    for (int i = 0; i < nfull - 2; i++) begin
      live = (n == 0) || (i < int'(n));
      if (live) begin
        exp_oe[i] = m[0];
        if (m[0]) exp_rd[i] = mdl_mem[a];
        if (m[1]) begin
          exp_we.push_back({a, tx[2+i]});
          mdl_mem[a] = tx[2+i];
        end
        a = a + 8'd1;
        if (m[0] && ((n == 0) || (i + 1 < int'(n))))
          exp_re.push_back(a);
      end
    end
  endtask

  task automatic spi_bits(input logic [7:0] v, input int nb,
                          output logic [7:0] rxv,
                          output int oec);
    rxv = 8'h00;
    oec = 0;
    for (int i = 7; i > 7 - nb; i--) begin
      SDI = v[i];
      #(HALF);
      SCK = 1'b1;
      rxv[i] = SDO;
      if (sdo_oe) oec++;
      #(HALF);
      SCK = 1'b0;
    end
  endtask

  task automatic run_txn(input int nfull, input int npart,
                         input bit do_rst);
    logic [7:0] junk;
    int         jc;
    int         lim;
    cap_we.delete();
    cap_re.delete();
    model_txn(nfull);
    CSB = 1'b0;
    #(HALF);
    for (int b = 0; b < nfull; b++)
      spi_bits(tx[b], 8, rx[b], oecnt[b]);
    if (npart > 0) spi_bits(tx[nfull], npart, junk, jc);
    if (do_rst) begin
      @(negedge clock) reset = 1'b1;
      repeat (3) @(negedge clock);
      reset = 1'b0;
      spi_bits(8'hA5, 4, junk, jc);
      spi_bits(8'h40, 8, junk, jc);
      spi_bits(8'h03, 8, junk, jc);
    end
    #(HALF);
    CSB = 1'b1;
    #(4 * HALF);
    chk("oe_idle", {31'd0, sdo_oe}, 32'd0);
    chk("we_cnt", cap_we.size(), exp_we.size());
    lim = (cap_we.size() < exp_we.size()) ?
          cap_we.size() : exp_we.size();
    for (int i = 0; i < lim; i++)
      chk("we_addr_data", {16'd0, cap_we[i]}, {16'd0, exp_we[i]});
    chk("re_cnt", cap_re.size(), exp_re.size());
    lim = (cap_re.size() < exp_re.size()) ?
          cap_re.size() : exp_re.size();
    for (int i = 0; i < lim; i++)
      chk("re_addr", {24'd0, cap_re[i]}, {24'd0, exp_re[i]});
    for (int b = 0; b < nfull && b < 2; b++)
      chk("oe_hdr", oecnt[b], 0);
    for (int b = 2; b < nfull; b++) begin
      chk("oe_data", oecnt[b], exp_oe[b-2] ? 8 : 0);
      if (exp_oe[b-2])
        chk("sdo_byte", {24'd0, rx[b]}, {24'd0, exp_rd[b-2]});
    end
  endtask

  initial begin
    int         nd;
    int         np;
    logic [1:0] m;
    logic [2:0] n;
    reset = 1'b1;
    SCK   = 1'b0;
    CSB   = 1'b1;
    SDI   = 1'b0;
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 8'($urandom);
      mdl_mem[i] = mem[i];
    end
    mem[3]     = 8'h11;
    mdl_mem[3] = 8'h11;
    repeat (5) @(negedge clock);
    chk("rst_sdo", {31'd0, SDO}, 32'd0);
    chk("rst_oe", {31'd0, sdo_oe}, 32'd0);
    chk("rst_addr", {24'd0, reg_addr}, 32'd0);
    chk("rst_wdata", {24'd0, reg_wdata}, 32'd0);
    chk("rst_we", {31'd0, reg_we}, 32'd0);
    chk("rst_re", {31'd0, reg_re}, 32'd0);
    reset = 1'b0;
    repeat (10) @(negedge clock);

    tx[0] = 8'h40; tx[1] = 8'h03; tx[2] = 8'h00;
    run_txn(3, 0, 1'b0);
    tx[0] = 8'h80; tx[1] = 8'h0B; tx[2] = 8'h01;
    run_txn(3, 0, 1'b0);
    tx[0] = 8'h40; tx[1] = 8'h00;
    for (int k = 0; k < 19; k++) tx[2+k] = 8'($urandom);
    run_txn(21, 0, 1'b0);
    tx[0] = 8'h80; tx[1] = 8'hFF; tx[2] = 8'hAA; tx[3] = 8'h55;
    run_txn(4, 0, 1'b0);
    tx[0] = 8'h50; tx[1] = 8'h10;
    tx[2] = 8'h00; tx[3] = 8'h00; tx[4] = 8'h00;
    run_txn(5, 0, 1'b0);
    tx[0] = 8'h80; tx[1] = 8'h20; tx[2] = 8'hC3;
    run_txn(2, 4, 1'b0);
    tx[0] = 8'h40; tx[1] = 8'h03; tx[2] = 8'h00;
    run_txn(3, 0, 1'b0);
    tx[0] = 8'h80; tx[1] = 8'h20; tx[2] = 8'hC3;
    run_txn(2, 4, 1'b1);
    tx[0] = 8'h40; tx[1] = 8'h03; tx[2] = 8'h00;
    run_txn(3, 0, 1'b0);
    tx[0] = 8'hC0; tx[1] = 8'h7E;
    tx[2] = 8'h12; tx[3] = 8'h34; tx[4] = 8'h56;
    run_txn(5, 0, 1'b0);

    for (int t = 0; t < 25; t++) begin
      m = 2'($urandom_range(0, 3));
      n = 3'($urandom_range(0, 7));
      tx[0] = {m, n, 3'($urandom)};
      tx[1] = 8'($urandom);
      nd = $urandom_range(0, 9);
      for (int k = 0; k <= nd; k++) tx[2+k] = 8'($urandom);
      np = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
      run_txn(2 + nd, np, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
